// File: rtl/axi_to_bp_encoder.sv
// Host command word stream to BedRock UCE mem command/response bridge.
// Optional macro AXI_TO_BP_WRITE_ACK_EN: writes return a zero reply word after the response.
package axi_to_bp_encoder_pkg;
  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1 = 3'd0,
    e_bedrock_msg_size_2 = 3'd1,
    e_bedrock_msg_size_4 = 3'd2,
    e_bedrock_msg_size_8 = 3'd3
  } bp_bedrock_msg_size_e;

  function automatic int paddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 40;
      default:          return 40;
    endcase
  endfunction

  function automatic int data_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 64;
      default:          return 64;
    endcase
  endfunction

  function automatic int payload_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 16;
      default:          return 16;
    endcase
  endfunction
endpackage

// state  | meaning
// E_HDR  | waiting for header word
// E_DATA | waiting for write data word
// E_CMD  | presenting BedRock command
// E_RESP | waiting for BedRock response
// E_OUT  | presenting reply word to host
module axi_to_bp_encoder
  import axi_to_bp_encoder_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int paddr_width_p = paddr_width(bp_params_p),
  localparam int payload_width_lp = payload_width(bp_params_p),
  localparam int uce_mem_data_width_lp = data_width(bp_params_p),
  localparam int uce_mem_hdr_width_lp = 4 + paddr_width_p + 3 + payload_width_lp,
  localparam int uce_mem_msg_width_lp = uce_mem_hdr_width_lp + uce_mem_data_width_lp
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [31:0]                     data_i,
  input  logic                            v_i,
  output logic                            ready_and_o,
  output logic [uce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_and_i,
  input  logic [uce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,
  output logic [31:0]                     data_o,
  output logic                            v_o,
  input  logic                            ready_i
);
  localparam int rep_lp = uce_mem_data_width_lp / 32;

  typedef enum logic [2:0] {E_HDR, E_DATA, E_CMD, E_RESP, E_OUT} state_e;

  state_e      state_r;
  logic        rdy_r, cmd_v_r, v_r, wr_r;
  logic [1:0]  size_r;
  logic [27:0] addr_r;
  logic [31:0] wdata_r, data_r;

  logic [31:0] resp_data, resp_masked, wword;
  bp_bedrock_mem_type_e cmd_type;
  bp_bedrock_msg_size_e cmd_size;
  logic [uce_mem_data_width_lp-1:0] cmd_data;
  logic unused_bits;

  assign resp_data = io_resp_i[uce_mem_hdr_width_lp +: 32];
  assign unused_bits = ^{data_i[30], io_resp_i[uce_mem_hdr_width_lp-1:0],
                         io_resp_i[uce_mem_msg_width_lp-1:uce_mem_hdr_width_lp+32]};

  always_comb begin
    resp_masked = resp_data;
    wword = wdata_r;
    cmd_size = e_bedrock_msg_size_4;
    case (size_r)
      2'd0: begin
        resp_masked = {24'b0, resp_data[7:0]};
        wword = {4{wdata_r[7:0]}};
        cmd_size = e_bedrock_msg_size_1;
      end
      2'd1: begin
        resp_masked = {16'b0, resp_data[15:0]};
        wword = {2{wdata_r[15:0]}};
        cmd_size = e_bedrock_msg_size_2;
      end
      default: ;
    endcase
  end

  // Sub-word writes replicate the active bytes so every lane carries the data.
  assign cmd_type = wr_r ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
  assign cmd_data = wr_r ? {rep_lp{wword}} : '0;
  assign io_cmd_o = {cmd_data, {payload_width_lp{1'b0}}, cmd_size,
                     {{(paddr_width_p-28){1'b0}}, addr_r}, cmd_type};

  assign ready_and_o    = rdy_r;
  assign io_cmd_v_o     = cmd_v_r;
  assign v_o            = v_r;
  assign data_o         = data_r;
  assign io_resp_yumi_o = (state_r == E_RESP) && io_resp_v_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= E_HDR;
      rdy_r   <= 1'b0;
      cmd_v_r <= 1'b0;
      v_r     <= 1'b0;
      wr_r    <= 1'b0;
      size_r  <= 2'b0;
      addr_r  <= 28'b0;
      wdata_r <= 32'b0;
      data_r  <= 32'b0;
    end else begin
      case (state_r)
        E_HDR: begin
          rdy_r <= 1'b1;
          if (v_i && rdy_r) begin
            wr_r   <= data_i[31];
            size_r <= data_i[29:28];
            addr_r <= data_i[27:0];
            if (data_i[31]) begin
              state_r <= E_DATA;
            end else begin
              state_r <= E_CMD;
              rdy_r   <= 1'b0;
              cmd_v_r <= 1'b1;
            end
          end
        end
        E_DATA: begin
          if (v_i && rdy_r) begin
            wdata_r <= data_i;
            state_r <= E_CMD;
            rdy_r   <= 1'b0;
            cmd_v_r <= 1'b1;
          end
        end
        E_CMD: begin
          if (io_cmd_ready_and_i) begin
            cmd_v_r <= 1'b0;
            state_r <= E_RESP;
          end
        end
        E_RESP: begin
          if (io_resp_v_i) begin
`ifdef AXI_TO_BP_WRITE_ACK_EN
            state_r <= E_OUT;
            v_r     <= 1'b1;
            data_r  <= wr_r ? 32'h0 : resp_masked;
`else
            if (wr_r) begin
              state_r <= E_HDR;
              rdy_r   <= 1'b1;
            end else begin
              state_r <= E_OUT;
              v_r     <= 1'b1;
              data_r  <= resp_masked;
            end
`endif
          end
        end
        E_OUT: begin
          if (ready_i) begin
            v_r     <= 1'b0;
            state_r <= E_HDR;
            rdy_r   <= 1'b1;
          end
        end
        default: state_r <= E_HDR;
      endcase
    end
  end
endmodule
